// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 scancode receiver.
//
// Contents:
//   ps2_state_e      frame FSM states (IDLE, DATA, PARITY, STOP)
//   PS2_EXT_PREFIX   0xE0, extended-key prefix byte
//   PS2_BRK_PREFIX   0xF0, break (key release) prefix byte
//   PS2_EVT_W        width of a queued key event {ext, brk, scancode[7:0]}
//   PS2_EXT_BIT      bit position of the ext flag inside an event
//   PS2_BRK_BIT      bit position of the brk flag inside an event
//   ps2_parity_ok()  odd-parity check over a data byte plus its parity bit
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  localparam int PS2_EVT_W   = 10;
  localparam int PS2_EXT_BIT = 9;
  localparam int PS2_BRK_BIT = 8;

  // PS/2 uses odd parity: the data byte and the parity bit together carry
  // an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [7:0] data_byte,
                                         input logic       parity_bit);
    return ^{data_byte, parity_bit};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo -- synchronous first-word-fall-through FIFO for key events.
//
// Parameters:
//   DEPTH      number of entries, power of two, at least 2
//   WIDTH      entry width
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset (empties the FIFO)
//   push       write request; ignored when full unless a pop happens too
//   push_data  word to write
//   pop_req    consumer accepts the head word this cycle
//   head_data  head word, forced to zero while empty
//   full       all DEPTH entries occupied
//   empty      no entries occupied
//   count      number of occupied entries (0..DEPTH)
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_req,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still accepted when the head is being drained. An empty FIFO never pops,
  // so a same-cycle push lands and becomes visible on the next cycle.
  assign do_pop  = pop_req & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx -- PS/2 keyboard receiver in the system clock domain.
//
// Synchronises and deglitches the keyboard clock/data lines, frames bytes
// (start, 8 data bits LSB-first, odd parity, stop), tracks the E0/F0
// prefixes and queues {ext, brk, scancode} events in a FWFT FIFO.
//
// Optional build macro:
//   PS2_TYPEMATIC_SUPPRESS_EN  drop keyboard auto-repeat makes (a make equal
//                              to the last held make is not queued)
//
// Ports:
//   clk              system clock
//   reset            asynchronous, active-high reset
//   PS2KeyboardClk   raw keyboard clock (asynchronous)
//   PS2KeyboardData  raw keyboard data (asynchronous)
//   code_valid       FIFO head holds an event
//   code_ready       consumer accepts the head this cycle
//   code_data        {ext, brk, scancode[7:0]} at the FIFO head
//   fifo_count       occupied FIFO entries
//   frame_err        one-cycle pulse on start/parity/stop/timeout error
//   overflow         one-cycle pulse when an event is dropped (FIFO full)
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          PS2KeyboardClk,
  input  logic                          PS2KeyboardData,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic [PS2_EVT_W-1:0]          code_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int         TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] FILT_MAX = 8'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       filt_clk_q;
  logic       filt_prev_q;
  logic [7:0] filt_cnt_q;
  logic       armed_q;
  logic [7:0] arm_cnt_q;
  logic       sample_p0;
  logic       sdata_p0;

  ps2_state_e      state_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            parity_ok_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            timeout;
  logic            stop_ok;
  logic            byte_good;
  logic            frm_err_c;

  logic                 ext_q;
  logic                 brk_q;
  logic                 is_prefix;
  logic                 repeat_c;
  logic                 vld_p1;
  logic [PS2_EVT_W-1:0] evt_p1;

  logic fifo_full;
  logic fifo_empty;

  // ---- stage p0: input conditioning ----
  // Both lines idle high, so the synchronisers and the filter preset to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2KeyboardClk};
      dat_sync_q <= {dat_sync_q[0], PS2KeyboardData};
    end
  end

  // The filtered clock follows the synchronised clock only after FILTER_LEN
  // consecutive samples that all differ from the current filtered level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_clk_q  <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      filt_prev_q <= filt_clk_q;
      if (clk_sync_q[1] == filt_clk_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FILT_MAX) begin
        filt_clk_q <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 8'd1;
      end
    end
  end

  // After reset the receiver ignores edges until the clock line has been
  // seen idle high for a full filter window, so a reset in the middle of a
  // frame resynchronises on the next genuine start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q   <= 1'b0;
      arm_cnt_q <= '0;
    end else if (!armed_q) begin
      if (!clk_sync_q[1]) begin
        arm_cnt_q <= '0;
      end else if (arm_cnt_q == FILT_MAX) begin
        armed_q <= 1'b1;
      end else begin
        arm_cnt_q <= arm_cnt_q + 8'd1;
      end
    end
  end

  assign sample_p0 = armed_q & filt_prev_q & ~filt_clk_q;
  assign sdata_p0  = dat_sync_q[1];

  // ---- stage p0: frame FSM ----
  // A sample event in the same cycle as the timeout limit wins: the frame
  // is still alive.
  assign timeout = (state_q != ST_IDLE) && !sample_p0 && (to_cnt_q == TO_MAX);
  assign stop_ok = sdata_p0 & parity_ok_q;

  assign byte_good = sample_p0 && (state_q == ST_STOP) && stop_ok;
  assign frm_err_c = timeout
                   || (sample_p0 && (state_q == ST_IDLE) && sdata_p0)
                   || (sample_p0 && (state_q == ST_STOP) && !stop_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      parity_ok_q <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      if ((state_q == ST_IDLE) || sample_p0) to_cnt_q <= '0;
      else                                  to_cnt_q <= to_cnt_q + TO_W'(1);

      if (timeout) begin
        state_q <= ST_IDLE;
      end else if (sample_p0) begin
        case (state_q)
          ST_IDLE: begin
            if (!sdata_p0) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end
          end
          ST_DATA: begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_ok_q <= ps2_parity_ok(shift_q, sdata_p0);
            state_q     <= ST_STOP;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Data bits arrive LSB-first; shifting right leaves bit 0 at the bottom.
  always_ff @(posedge clk) begin
    if (sample_p0 && (state_q == ST_DATA)) shift_q <= {sdata_p0, shift_q[7:1]};
  end

  // ---- stage p1: prefix decoder / event register ----
  assign is_prefix = (shift_q == PS2_EXT_PREFIX) || (shift_q == PS2_BRK_PREFIX);

`ifdef PS2_TYPEMATIC_SUPPRESS_EN
  logic       held_q;
  logic [8:0] last_make_q;

  assign repeat_c = !brk_q && held_q && (last_make_q == {ext_q, shift_q});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q <= 1'b0;
    end else if (byte_good && !is_prefix) begin
      if (!brk_q)                               held_q <= 1'b1;
      else if (last_make_q == {ext_q, shift_q}) held_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (byte_good && !is_prefix && !brk_q) last_make_q <= {ext_q, shift_q};
  end
`else
  assign repeat_c = 1'b0;
`endif

  // Any frame error drops pending prefixes so they never attach to a later
  // unrelated byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (frm_err_c) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_good) begin
        if (shift_q == PS2_EXT_PREFIX) begin
          ext_q <= 1'b1;
        end else if (shift_q == PS2_BRK_PREFIX) begin
          brk_q <= 1'b1;
        end else begin
          ext_q  <= 1'b0;
          brk_q  <= 1'b0;
          vld_p1 <= !repeat_c;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (byte_good) begin
      evt_p1[PS2_EXT_BIT] <= ext_q;
      evt_p1[PS2_BRK_BIT] <= brk_q;
      evt_p1[7:0]         <= shift_q;
    end
  end

  // ---- stage p2: event FIFO ----
  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_EVT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_p1),
    .push_data (evt_p1),
    .pop_req   (code_ready),
    .head_data (code_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign code_valid = ~fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= frm_err_c;
      overflow  <= vld_p1 & fifo_full & ~(code_valid & code_ready);
    end
  end

endmodule
